led_dir_indicator: RTL and testbench

//   Parametrised status/direction LED driver. Two status LEDs show idle vs

---
 rtl/led_dir_indicator.sv | 150 +++++++++++++++
 tb/tb_led_dir_indicator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_dir_indicator.sv
// led_dir_indicator
//   Status/direction LED driver. LED[0]/LED[1] show idle/running; the
//   one-hot field LED[NUM_DIR+1:2] shows the active direction, captured from
//   a prioritised SIGNAL bus (bit 0 wins). A captured direction can be held
//   for HOLD_CYCLES cycles after the requests go quiet (0 = held until EN
//   drops), and can optionally blink with a half-period of BLINK_HALF cycles.
//
// Ports
//   CLK        in   system clock, rising edge
//   RST        in   asynchronous reset, active-high
//   EN         in   1 = run, 0 = return to idle (beats SIGNAL)
//   MODE_BLINK in   0 = steady direction LED, 1 = blinking
//   SIGNAL     in   direction requests, bit k = channel k; bits >= NUM_DIR ignored
//   LED        out  [0] idle, [1] run, [NUM_DIR+1:2] one-hot direction
//   DIR_VALID  out  a direction is currently latched (blink does not affect it)
//   DIR_IDX    out  index of the latched direction, 0 when none
//   DBG_STATE  out  FSM state, 1 = RUN, 0 = IDLE
//
// Handshake: none. SIGNAL is a level-sampled request bus; every rising edge
// samples it, and all outputs follow one cycle later.
module led_dir_indicator #(
    parameter int NUM_DIR     = 4,
    parameter int SIG_W       = 8,
    parameter int HOLD_CYCLES = 0,
    parameter int BLINK_HALF  = 1,
    localparam int IDX_W      = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               MODE_BLINK,
    input  logic [SIG_W-1:0]   SIGNAL,
    output logic [NUM_DIR+1:0] LED,
    output logic               DIR_VALID,
    output logic [IDX_W-1:0]   DIR_IDX,
    output logic               DBG_STATE
);

    localparam int HC_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [NUM_DIR-1:0] dir_q, dir_n;
    logic [HC_W-1:0]    hold_cnt, hold_n;
    logic [BC_W-1:0]    blink_cnt, bcnt_n;
    logic               phase, phase_n;

    logic [NUM_DIR-1:0] req, req_oh, field_n;
    logic [IDX_W-1:0]   idx_n;
    logic [NUM_DIR+1:0] led_n;

    // Upper SIGNAL bits are don't-care by design.
    logic unused_sig;
    assign unused_sig = ^SIGNAL;

    assign DBG_STATE = (state == S_RUN);

    always_comb begin
        req     = SIGNAL[NUM_DIR-1:0];
        // Isolate the lowest set bit: channel 0 has the highest priority.
        req_oh  = req & (~req + NUM_DIR'(1));
        state_n = state;
        dir_n   = dir_q;
        hold_n  = hold_cnt;
        bcnt_n  = blink_cnt;
        phase_n = phase;

        case (state)
            S_IDLE: begin
                if (EN)
                    state_n = S_RUN;
            end
            S_RUN: begin
                if (!EN) begin
                    state_n = S_IDLE;
                    dir_n   = '0;
                    hold_n  = '0;
                    bcnt_n  = '0;
                    phase_n = 1'b1;
                end else begin
                    if (req != '0) begin
                        dir_n  = req_oh;
                        hold_n = HC_W'(HOLD_CYCLES);
                    end else if (HOLD_CYCLES != 0) begin
                        // hold_cnt == 0 means nothing is being held: stay put.
                        if (hold_cnt == HC_W'(1)) begin
                            dir_n  = '0;
                            hold_n = '0;
                        end else if (hold_cnt > HC_W'(1)) begin
                            hold_n = hold_cnt - HC_W'(1);
                        end
                    end

                    // A new direction restarts the blink in its on-phase so
                    // it is visible on the very next cycle.
                    if (dir_n != dir_q) begin
                        bcnt_n  = '0;
                        phase_n = 1'b1;
                    end else if (dir_q != '0) begin
                        if (blink_cnt == BC_W'(BLINK_HALF - 1)) begin
                            bcnt_n  = '0;
                            phase_n = ~phase;
                        end else begin
                            bcnt_n = blink_cnt + BC_W'(1);
                        end
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        // MODE_BLINK only masks the displayed field; the counter keeps running.
        field_n = dir_n & {NUM_DIR{phase_n | ~MODE_BLINK}};
        led_n   = {field_n, (state_n == S_RUN), (state_n == S_IDLE)};

        idx_n = '0;
        for (int k = 0; k < NUM_DIR; k++) begin
            if (dir_n[k])
                idx_n = IDX_W'(k);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            dir_q     <= '0;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b1;
            LED       <= {{NUM_DIR{1'b0}}, 2'b01};
            DIR_VALID <= 1'b0;
            DIR_IDX   <= '0;
        end else begin
            state     <= state_n;
            dir_q     <= dir_n;
            hold_cnt  <= hold_n;
            blink_cnt <= bcnt_n;
            phase     <= phase_n;
            LED       <= led_n;
            DIR_VALID <= |dir_n;
            DIR_IDX   <= idx_n;
        end
    end

endmodule

// File: tb/tb_led_dir_indicator.sv
// Bench for led_dir_indicator: two instances share one stimulus stream,
// one with a 3-cycle hold and one sticky (HOLD_CYCLES = 0), both with a
// blink half-period of 2. A behavioural model tracks, per instance, the
// running flag, the latched channel, edges since the last request and edges
// since the direction last changed, and derives the outputs from those.
module tb_led_dir_indicator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] sig = '0;

    logic [5:0] led_h, led_s;
    logic       val_h, val_s;
    logic [1:0] idx_h, idx_s;
    logic       dbg_h, dbg_s;

    int n_chk  = 0;
    int n_fail = 0;

    localparam int BH = 2;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    led_dir_indicator #(.NUM_DIR(4), .SIG_W(8), .HOLD_CYCLES(3), .BLINK_HALF(BH)) dut_h (
        .CLK(clk), .RST(rst), .EN(en), .MODE_BLINK(mode), .SIGNAL(sig),
        .LED(led_h), .DIR_VALID(val_h), .DIR_IDX(idx_h), .DBG_STATE(dbg_h)
    );

    led_dir_indicator #(.NUM_DIR(4), .SIG_W(8), .HOLD_CYCLES(0), .BLINK_HALF(BH)) dut_s (
        .CLK(clk), .RST(rst), .EN(en), .MODE_BLINK(mode), .SIGNAL(sig),
        .LED(led_s), .DIR_VALID(val_s), .DIR_IDX(idx_s), .DBG_STATE(dbg_s)
    );

    // ---------------- model ----------------
    typedef struct {
        bit         run;
        int         idx;    // -1 = no direction
        int         quiet;  // edges since the last request edge
        int         age;    // edges since the direction last changed
        logic [5:0] led;
        logic       val;
        logic [1:0] didx;
    } model_t;

    function automatic model_t m_reset();
        model_t r;
        r.run   = 1'b0;
        r.idx   = -1;
        r.quiet = 0;
        r.age   = 0;
        r.led   = 6'b000001;
        r.val   = 1'b0;
        r.didx  = 2'd0;
        return r;
    endfunction

    function automatic model_t m_step(input model_t m, input int hold,
                                      input logic e, input logic md, input logic [7:0] s);
        model_t r = m;
        int     win = -1;
        int     nidx;
        bit     on;
        for (int k = 3; k >= 0; k--)
            if (s[k]) win = k;
        if (!r.run) begin
            if (e) r.run = 1'b1;
        end else if (!e) begin
            r.run   = 1'b0;
            r.idx   = -1;
            r.quiet = 0;
            r.age   = 0;
        end else begin
            nidx = r.idx;
            if (win >= 0) begin
                nidx    = win;
                r.quiet = 0;
            end else begin
                if (r.quiet < 100000) r.quiet++;
                if (hold != 0 && r.quiet >= hold) nidx = -1;
            end
            if (nidx != r.idx) r.age = 0;
            else r.age++;
            r.idx = nidx;
        end
        on    = !md || (((r.age / BH) % 2) == 0);
        r.led = {4'b0000, r.run, !r.run};
        if (r.idx >= 0 && on) r.led[2 + r.idx] = 1'b1;
        r.val  = (r.idx >= 0);
        r.didx = (r.idx >= 0) ? 2'(r.idx) : 2'd0;
        return r;
    endfunction

    model_t m_h = m_reset();
    model_t m_s = m_reset();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_h <= m_reset();
            m_s <= m_reset();
        end else begin
            m_h <= m_step(m_h, 3, en, mode, sig);
            m_s <= m_step(m_s, 0, en, mode, sig);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge, well away from the active edge.
    always @(negedge clk) begin
        chk("mdl_led_h", 32'(led_h), 32'(m_h.led));
        chk("mdl_val_h", 32'(val_h), 32'(m_h.val));
        chk("mdl_idx_h", 32'(idx_h), 32'(m_h.didx));
        chk("mdl_dbg_h", 32'(dbg_h), 32'(m_h.run));
        chk("mdl_led_s", 32'(led_s), 32'(m_s.led));
        chk("mdl_val_s", 32'(val_s), 32'(m_s.val));
        chk("mdl_idx_s", 32'(idx_s), 32'(m_s.didx));
        chk("mdl_dbg_s", 32'(dbg_s), 32'(m_s.run));
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic e, input logic md, input logic [7:0] s);
        en   = e;
        mode = md;
        sig  = s;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        bit blink_on [7] = '{1, 1, 0, 0, 1, 1, 0};

        #1 rst = 1'b1;
        #2;
        chk("rst_led_h", 32'(led_h), 32'(6'b000001));
        chk("rst_val_h", 32'(val_h), 32'(1'b0));
        chk("rst_led_s", 32'(led_s), 32'(6'b000001));
        @(posedge clk);
        #1 rst = 1'b0;

        // Enter RUN
        cyc(1, 0, 8'h00);
        chk("run_led", 32'(led_h), 32'(6'b000010));

        // Priority: bits 1 and 3 set -> channel 1
        cyc(1, 0, 8'b0000_1010);
        chk("prio_led", 32'(led_h), 32'(6'b001010));
        chk("prio_idx", 32'(idx_h), 32'(2'd1));
        // Bit 4 alone is outside the channel range: no capture
        cyc(1, 0, 8'h10);
        chk("ign_bit4", 32'(led_h), 32'(6'b001010));

        // Hold of 3 cycles after the last request edge
        cyc(1, 0, 8'h01);
        chk("cap0_led", 32'(led_h), 32'(6'b000110));
        chk("cap0_idx", 32'(idx_h), 32'(2'd0));
        cyc(1, 0, 8'h00);
        chk("hold_q1", 32'(led_h), 32'(6'b000110));
        cyc(1, 0, 8'h00);
        chk("hold_q2", 32'(led_h), 32'(6'b000110));
        cyc(1, 0, 8'h00);
        chk("hold_exp_led", 32'(led_h), 32'(6'b000010));
        chk("hold_exp_val", 32'(val_h), 32'(1'b0));
        chk("sticky_q3", 32'(led_s), 32'(6'b000110));

        // Re-request on the 2nd quiet edge reloads the hold
        cyc(1, 0, 8'h01);
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h01);
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h00);
        chk("hold_ext", 32'(led_h), 32'(6'b000110));
        cyc(1, 0, 8'h00);
        chk("hold_ext_end", 32'(led_h), 32'(6'b000010));

        // Sticky instance keeps channel 3 through 50 quiet cycles
        cyc(1, 0, 8'h08);
        for (int i = 0; i < 50; i++) begin
            cyc(1, 0, 8'h00);
            chk("sticky_led", 32'(led_s), 32'(6'b100010));
        end
        chk("hold3_cleared", 32'(val_h), 32'(1'b0));

        // Blink: 2 on, 2 off, repeating; DIR_VALID unaffected
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 8'h04);
            chk("blink_led_h", 32'(led_h), 32'(blink_on[i] ? 6'b010010 : 6'b000010));
            chk("blink_led_s", 32'(led_s), 32'(blink_on[i] ? 6'b010010 : 6'b000010));
            chk("blink_val_h", 32'(val_h), 32'(1'b1));
        end
        // New direction during the off-phase shows immediately
        cyc(1, 1, 8'h01);
        chk("blink_new_h", 32'(led_h), 32'(6'b000110));
        chk("blink_new_s", 32'(led_s), 32'(6'b000110));
        // Mode is a pure mask: counter keeps going while steady
        cyc(1, 0, 8'h01);
        chk("mask_steady", 32'(led_h), 32'(6'b000110));
        cyc(1, 1, 8'h01);
        chk("mask_off2", 32'(led_h), 32'(6'b000010));
        cyc(1, 1, 8'h01);
        chk("mask_off3", 32'(led_h), 32'(6'b000010));
        cyc(1, 1, 8'h01);
        chk("mask_on4", 32'(led_h), 32'(6'b000110));

        // EN=0 beats SIGNAL and clears everything
        cyc(0, 1, 8'h01);
        chk("en0_led_h", 32'(led_h), 32'(6'b000001));
        chk("en0_val_h", 32'(val_h), 32'(1'b0));
        chk("en0_led_s", 32'(led_s), 32'(6'b000001));

        // Async reset in the middle of a hold
        cyc(1, 0, 8'h00);
        cyc(1, 0, 8'h02);
        chk("cap1_led", 32'(led_h), 32'(6'b001010));
        cyc(1, 0, 8'h00);
        #2 rst = 1'b1;
        #1;
        chk("arst_led_h", 32'(led_h), 32'(6'b000001));
        chk("arst_val_h", 32'(val_h), 32'(1'b0));
        chk("arst_idx_h", 32'(idx_h), 32'(2'd0));
        chk("arst_led_s", 32'(led_s), 32'(6'b000001));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 8'h00);
        chk("rerun_led", 32'(led_h), 32'(6'b000010));
        cyc(1, 0, 8'h80);
        chk("ign_bit7", 32'(led_h), 32'(6'b000010));
        cyc(1, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
